// File: rtl/sched_pkg.sv
// sched_pkg: shared state encoding and return_val field layout for thread_sched.
package sched_pkg;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
   localparam int DONE_LSB    = 0;
   localparam int SPUR_LSB    = 8;
   localparam int TIMEOUT_BIT = 31;
endpackage

// File: rtl/sched_sat_ctr.sv
// sched_sat_ctr: saturating up-counter with synchronous clear and async reset.
module sched_sat_ctr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (clr) count <= '0;
      else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/thread_sched.sv
// thread_sched: launches NUM_TASKS tasks in order with bounded concurrency,
// collects completions and reports done mask, spurious count and timeout.
module thread_sched
   import sched_pkg::*;
#(
   parameter int NUM_TASKS      = 3,
   parameter int MAX_INFLIGHT   = 2,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 memory_controller_waitrequest,
   input  logic [NUM_TASKS-1:0] task_finish,
   output logic [NUM_TASKS-1:0] task_start,
   output logic                 busy,
   output logic                 finish,
   output logic [31:0]          return_val
);
   localparam int IW = $clog2(NUM_TASKS + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   state_t state, next;
   logic [IW-1:0] idx;
   logic [NUM_TASKS-1:0] inflight, done, acc, spur, launch_vec;
   logic [7:0] spur_cnt;
   logic [TW-1:0] wait_cnt;
   logic active, launch, timed_out, tflag, accept_start;
   int nflight;
   always_comb begin
      nflight = 0;
      for (int i = 0; i < NUM_TASKS; i++) nflight = nflight + int'(inflight[i]);
      active       = state == LAUNCH || state == WAIT;
      accept_start = state == IDLE && start;
      // a finish arriving in its own launch-pulse cycle is treated as spurious
      acc          = active ? task_finish & inflight & ~task_start : '0;
      spur         = active ? task_finish & ~acc : '0;
      launch       = state == LAUNCH && !memory_controller_waitrequest && nflight < MAX_INFLIGHT;
      launch_vec   = launch ? NUM_TASKS'(1) << idx : '0;
      timed_out    = state == WAIT && wait_cnt >= TW'(TIMEOUT_CYCLES - 1);
      next = state;
      unique case (state)
         IDLE:   next = start ? LAUNCH : IDLE;
         LAUNCH: next = launch && idx == IW'(NUM_TASKS - 1) ? WAIT : LAUNCH;
         WAIT:   next = (&(done | acc)) || timed_out ? DONE : WAIT;
         DONE:   next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= next;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         task_start <= '0;
         finish     <= 1'b0;
         busy       <= 1'b0;
         idx        <= '0;
         inflight   <= '0;
         done       <= '0;
         tflag      <= 1'b0;
      end else begin
         task_start <= launch_vec;
         finish     <= state == WAIT && next == DONE;
         if (accept_start) begin
            busy     <= 1'b1;
            idx      <= '0;
            inflight <= '0;
            done     <= '0;
            tflag    <= 1'b0;
         end else begin
            if (state == DONE) busy <= 1'b0;
            if (launch) idx <= idx + 1'b1;
            inflight <= (inflight & ~acc) | launch_vec;
            done     <= done | acc;
            if (state == WAIT && next == DONE) tflag <= timed_out && !(&(done | acc));
         end
      end
   sched_sat_ctr #(.WIDTH(8)) u_spur (
      .clk(clk), .reset(reset), .clr(accept_start), .inc(|spur), .count(spur_cnt)
   );
   sched_sat_ctr #(.WIDTH(TW)) u_wait (
      .clk(clk), .reset(reset), .clr(accept_start), .inc(state == WAIT), .count(wait_cnt)
   );
   always_comb begin
      return_val = '0;
      return_val[DONE_LSB +: NUM_TASKS] = done;
      return_val[SPUR_LSB +: 8] = spur_cnt;
      return_val[TIMEOUT_BIT] = tflag;
   end
endmodule

// File: tb/tb_thread_sched.sv
// tb_thread_sched: directed run table plus randomized traffic against a
// behavioural scheduler model.
module tb_thread_sched;
   localparam int N = 3, MX = 2, TO = 1000;
   logic clk = 0, reset = 1, start = 0, wr = 0;
   logic [N-1:0] tf = '0, ts;
   logic busy, finish;
   logic [31:0] rv;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   thread_sched #(.NUM_TASKS(N), .MAX_INFLIGHT(MX), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .memory_controller_waitrequest(wr),
      .task_finish(tf), .task_start(ts), .busy(busy), .finish(finish), .return_val(rv)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask
   // directed runs: tasks finish `delay` cycles after their launch pulse
   typedef struct {
      int stall; int delay; bit hang; int spur_at; int spur_n; bit hold;
      int t0; int t2; int fin; logic [31:0] rv;
   } row_t;
   row_t rows[7];
   task automatic run_row(input row_t r, input int k);
      int st[N];
      int fin = -1;
      logic [31:0] got = '0;
      bit bok = 1, q = 1;
      for (int i = 0; i < N; i++) st[i] = -1;
      start = 1; wr = 0; tf = '0;
      for (int c = 0; c < 1500 && fin < 0; c++) begin
         @(posedge clk); #1;
         start = r.hold;
         wr = c < r.stall;
         for (int i = 0; i < N; i++) if (ts[i] && st[i] < 0) st[i] = c;
         tf = '0;
         for (int i = 0; i < N; i++)
            if (st[i] >= 0 && c == st[i] + r.delay && !(r.hang && i == N - 1)) tf[i] = 1;
         if (c >= r.spur_at && c < r.spur_at + r.spur_n) tf[N-1] = 1;
         if (!busy) bok = 0;
         if (finish) begin fin = c; got = rv; end
      end
      @(posedge clk); #1;
      start = 0; tf = '0;
      chk($sformatf("row%0d_t0", k), st[0], r.t0);
      chk($sformatf("row%0d_t2", k), st[N-1], r.t2);
      chk($sformatf("row%0d_fin", k), fin, r.fin);
      chk($sformatf("row%0d_rv", k), got, r.rv);
      chk($sformatf("row%0d_busy_run", k), bok, 1);
      chk($sformatf("row%0d_busy_after", k), busy, 0);
      for (int j = 0; j < 5; j++) begin
         if (busy || finish || ts != 0 || rv !== got) q = 0;
         @(posedge clk); #1;
      end
      chk($sformatf("row%0d_quiet_hold", k), q, 1);
   endtask
   // behavioural model: run/finish flags, launch cursor, per-task bit arrays
   bit m_run, m_fin, m_to;
   int m_next, m_spur, m_wcnt;
   bit [N-1:0] m_fl, m_dn, m_ts;
   function automatic void model_reset();
      m_run = 0; m_fin = 0; m_to = 0; m_next = 0; m_spur = 0; m_wcnt = 0;
      m_fl = '0; m_dn = '0; m_ts = '0;
   endfunction
   function automatic void model_edge(input bit s, input bit w, input logic [N-1:0] f);
      int cnt = 0;
      bit any_spur = 0;
      bit [N-1:0] nts = '0, acc;
      for (int i = 0; i < N; i++) cnt += int'(m_fl[i]);
      if (m_fin) m_fin = 0;
      else if (!m_run) begin
         if (s) begin
            m_run = 1; m_next = 0; m_fl = '0; m_dn = '0; m_spur = 0; m_wcnt = 0; m_to = 0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            acc[i] = f[i] && m_fl[i] && !m_ts[i];
            if (f[i] && !acc[i]) any_spur = 1;
         end
         if (any_spur && m_spur < 255) m_spur++;
         m_fl &= ~acc;
         m_dn |= acc;
         if (m_next == N) begin
            m_wcnt++;
            if (&m_dn) begin m_run = 0; m_fin = 1; end
            else if (m_wcnt == TO) begin m_run = 0; m_fin = 1; m_to = 1; end
         end else if (!w && cnt < MX) begin
            m_fl[m_next] = 1; nts[m_next] = 1; m_next++;
         end
      end
      m_ts = nts;
   endfunction
   function automatic logic [31:0] model_rv();
      logic [31:0] v = '0;
      v[N-1:0] = m_dn;
      v[15:8] = m_spur[7:0];
      v[31] = m_to;
      return v;
   endfunction
   initial begin
      int due[N];
      bit q;
      rows[0] = '{0, 5, 0, -1, 0, 0, 1, 8, 14, 32'h7};
      rows[1] = '{10, 5, 0, -1, 0, 0, 11, 18, 24, 32'h7};
      rows[2] = '{3, 5, 0, -1, 0, 0, 4, 11, 17, 32'h7};
      rows[3] = '{0, 5, 1, -1, 0, 0, 1, 8, 1008, 32'h8000_0003};
      rows[4] = '{0, 5, 0, 3, 1, 0, 1, 8, 14, 32'h107};
      rows[5] = '{0, 320, 0, 2, 300, 0, 1, 323, 644, 32'hFF07};
      rows[6] = '{0, 5, 0, -1, 0, 1, 1, 8, 14, 32'h7};
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctl", {ts, busy, finish}, 0);
      chk("reset_rv", rv, 0);
      reset = 0;
      @(posedge clk); #1;
      chk("release_quiet", {ts, busy, finish}, 0);
      for (int k = 0; k < 7; k++) run_row(rows[k], k);
      // asynchronous reset in the middle of a run
      start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("midrun_busy", busy, 1);
      #2 reset = 1;
      #1;
      chk("async_reset_ctl", {ts, busy, finish}, 0);
      chk("async_reset_rv", rv, 0);
      @(posedge clk); #1;
      reset = 0;
      q = 1;
      for (int j = 0; j < 4; j++) begin
         if (busy || finish || ts != 0 || rv != 0) q = 0;
         @(posedge clk); #1;
      end
      chk("post_reset_quiet", q, 1);
      run_row(rows[0], 7);
      // randomized traffic
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      model_reset();
      for (int i = 0; i < N; i++) due[i] = 0;
      for (int c = 0; c < 4000; c++) begin
         start = $urandom_range(0, 7) == 0;
         wr = $urandom_range(0, 3) == 0;
         tf = '0;
         for (int i = 0; i < N; i++) if (m_ts[i]) due[i] = c + int'($urandom_range(1, 12));
         for (int i = 0; i < N; i++) if (m_fl[i] && !m_ts[i] && due[i] == c) tf[i] = 1;
         if ($urandom_range(0, 15) == 0) begin
            int j = int'($urandom_range(0, N - 1));
            if (!m_fl[j] || m_ts[j]) tf[j] = 1;
         end
         @(posedge clk);
         model_edge(start, wr, tf);
         #1;
         chk("rnd_task_start", ts, m_ts);
         chk("rnd_busy", busy, m_run || m_fin);
         chk("rnd_finish", finish, m_fin);
         chk("rnd_return_val", rv, model_rv());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
